// File: rtl/tdd_slot_scheduler.sv
// TDD slot scheduler for the optical PPM link: frames time into guarded TX/RX slots,
// launches the transmitter, and arms the receive synchronizer and counts its bytes.
module tdd_slot_scheduler #(
   parameter int unsigned SLOT_CYCLES  = 40000,
   parameter int unsigned GUARD_CYCLES = 64,
   parameter int unsigned NUM_SLOTS    = 5,
   parameter int unsigned RX_BYTES     = 149
) (
   input  logic                 clk4m_i,
   input  logic                 reset_i,
   input  logic                 enable_i,
   input  logic [NUM_SLOTS-1:0] tx_slot_map_i,
   input  logic                 tx_req_i,
   input  logic                 tx_busy_i,
   input  logic                 rx_valid_i,
   output logic [2:0]           slot_idx_o,
   output logic                 slot_tick_o,
   output logic                 tx_window_o,
   output logic                 tx_start_o,
   output logic                 tx_overrun_o,
   output logic                 rx_sync_rst_n_o,
   output logic                 rx_window_o,
   output logic [7:0]           rx_byte_count_o,
   output logic                 rx_frame_done_o,
   output logic                 rx_timeout_o
);

   localparam int unsigned TIMER_W = $clog2(SLOT_CYCLES);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_GUARD   = 3'd1;
   localparam logic [2:0] S_TX_ACT  = 3'd2;
   localparam logic [2:0] S_RX_ACT  = 3'd3;
   localparam logic [2:0] S_RX_DONE = 3'd4;

   localparam logic [TIMER_W-1:0] T_ZERO       = '0;
   localparam logic [TIMER_W-1:0] T_ONE        = TIMER_W'(1);
   localparam logic [TIMER_W-1:0] T_LAST       = TIMER_W'(SLOT_CYCLES - 1);
   localparam logic [TIMER_W-1:0] T_GUARD_LAST = TIMER_W'(GUARD_CYCLES - 1);
   localparam logic [2:0]         LAST_SLOT    = 3'(NUM_SLOTS - 1);
   localparam logic [7:0]         RX_LAST      = 8'(RX_BYTES - 1);

   logic [2:0]         state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [2:0]         slot_idx_q, slot_idx_d;
   logic               slot_tx_q, slot_tx_d;
   logic [7:0]         count_q, count_d;

   logic slot_end;
   logic slot_is_tx;
   logic final_byte;
   logic tx_start_d;
   logic tx_overrun_d;
   logic rx_frame_done_d;
   logic rx_timeout_d;

   assign slot_end   = (timer_q == T_LAST);
   assign final_byte = rx_valid_i && (count_q == RX_LAST);
   // With a one-cycle guard the latch and the activation decision share an edge.
   assign slot_is_tx = (timer_q == T_ZERO) ? tx_slot_map_i[slot_idx_q] : slot_tx_q;

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      state_d         = state_q;
      timer_d         = timer_q;
      slot_idx_d      = slot_idx_q;
      slot_tx_d       = slot_tx_q;
      count_d         = count_q;
      tx_start_d      = 1'b0;
      tx_overrun_d    = 1'b0;
      rx_frame_done_d = 1'b0;
      rx_timeout_d    = 1'b0;

      if (!enable_i) begin
         state_d    = S_IDLE;
         timer_d    = T_ZERO;
         slot_idx_d = 3'd0;
         slot_tx_d  = 1'b0;
         count_d    = 8'd0;
      end else if (state_q == S_IDLE) begin
         state_d    = S_GUARD;
         timer_d    = T_ZERO;
         slot_idx_d = 3'd0;
         count_d    = 8'd0;
      end else begin
         timer_d = slot_end ? T_ZERO : timer_q + T_ONE;
         if (slot_end) begin
            slot_idx_d = (slot_idx_q == LAST_SLOT) ? 3'd0 : slot_idx_q + 3'd1;
         end

         case (state_q)
            S_GUARD: begin
               // The previous slot's count stays visible through timer 0, then clears.
               if (timer_q == T_ZERO) begin
                  slot_tx_d = tx_slot_map_i[slot_idx_q];
                  count_d   = 8'd0;
               end
               if (timer_q == T_GUARD_LAST) begin
                  state_d    = slot_is_tx ? S_TX_ACT : S_RX_ACT;
                  tx_start_d = slot_is_tx && tx_req_i;
               end
            end

            S_TX_ACT: begin
               if (slot_end) begin
                  state_d      = S_GUARD;
                  tx_overrun_d = tx_busy_i;
               end
            end

            S_RX_ACT: begin
               if (rx_valid_i) begin
                  count_d = count_q + 8'd1;
               end
               if (final_byte) begin
                  state_d         = S_RX_DONE;
                  rx_frame_done_d = 1'b1;
               end else if (slot_end) begin
                  rx_timeout_d = 1'b1;
               end
               if (slot_end) begin
                  state_d = S_GUARD;
               end
            end

            S_RX_DONE: begin
               if (slot_end) begin
                  state_d = S_GUARD;
               end
            end

            default: begin
               state_d    = S_IDLE;
               timer_d    = T_ZERO;
               slot_idx_d = 3'd0;
               count_d    = 8'd0;
            end
         endcase
      end
   end

   // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge clk4m_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         timer_q    <= T_ZERO;
         slot_idx_q <= 3'd0;
         slot_tx_q  <= 1'b0;
         count_q    <= 8'd0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         slot_idx_q <= slot_idx_d;
         slot_tx_q  <= slot_tx_d;
         count_q    <= count_d;
      end
   end

   // Outputs are flopped from the next-state decode so they track state/timer with no input path.
   always_ff @(posedge clk4m_i or posedge reset_i) begin
      if (reset_i) begin
         slot_idx_o      <= 3'd0;
         slot_tick_o     <= 1'b0;
         tx_window_o     <= 1'b0;
         tx_start_o      <= 1'b0;
         tx_overrun_o    <= 1'b0;
         rx_sync_rst_n_o <= 1'b0;
         rx_window_o     <= 1'b0;
         rx_byte_count_o <= 8'd0;
         rx_frame_done_o <= 1'b0;
         rx_timeout_o    <= 1'b0;
      end else begin
         slot_idx_o      <= slot_idx_d;
         slot_tick_o     <= (state_d != S_IDLE) && (timer_d == T_ZERO);
         tx_window_o     <= (state_d == S_TX_ACT);
         tx_start_o      <= tx_start_d;
         tx_overrun_o    <= tx_overrun_d;
         rx_sync_rst_n_o <= (state_d == S_RX_ACT);
         rx_window_o     <= (state_d == S_RX_ACT);
         rx_byte_count_o <= count_d;
         rx_frame_done_o <= rx_frame_done_d;
         rx_timeout_o    <= rx_timeout_d;
      end
   end

endmodule
